// File: rtl/osd_text_compositor_if.sv
// Pixel stream, composited output and CPU text-RAM port of osd_text_compositor.
// The master modport is the upstream/CPU side and the slave modport is the compositor.
interface osd_text_compositor_if #(
    parameter int unsigned FRAME_COUNT = 2
);
    localparam int unsigned FSEL_W = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;

    logic                     pixel_valid;
    logic [9:0]               pixel_x_pos;
    logic [9:0]               pixel_y_pos;
    logic [8*FRAME_COUNT-1:0] frame_pixels;
    logic [FSEL_W-1:0]        frame_select;
    logic                     frame_start;
    logic                     osd_display;
    logic                     text_we;
    logic [9:0]               text_addr;
    logic [7:0]               text_wdata;
    logic                     text_ready;
    logic                     pixel_out_valid;
    logic [7:0]               pixel_red;
    logic [7:0]               pixel_green;
    logic [7:0]               pixel_blue;

    modport master (
        output pixel_valid, pixel_x_pos, pixel_y_pos, frame_pixels, frame_select,
        output frame_start, osd_display, text_we, text_addr, text_wdata,
        input  text_ready, pixel_out_valid, pixel_red, pixel_green, pixel_blue
    );

    modport slave (
        input  pixel_valid, pixel_x_pos, pixel_y_pos, frame_pixels, frame_select,
        input  frame_start, osd_display, text_we, text_addr, text_wdata,
        output text_ready, pixel_out_valid, pixel_red, pixel_green, pixel_blue
    );
endinterface

// File: rtl/osd_text_compositor.sv
// Three-stage frame-buffer select / RGB332 expansion with a blinking character-grid overlay.
// Text RAM is cleared to spaces after every reset before CPU writes are accepted.
module osd_text_compositor #(
    parameter int unsigned FRAME_COUNT  = 2,
    parameter int unsigned OSD_ROWS     = 24,
    parameter int unsigned OSD_COLS     = 32,
    parameter int unsigned OSD_X0       = 160,
    parameter int unsigned OSD_Y0       = 24,
    parameter int unsigned CELL_W       = 10,
    parameter int unsigned CELL_H       = 18,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                   clock,
    input  logic                   reset_n,
    osd_text_compositor_if.slave   bus,
    output logic [4:0]             font_character,
    output logic [3:0]             font_line,
    output logic [2:0]             font_column,
    input  logic                   font_pixel
);
    localparam int unsigned FSEL_W = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
    localparam int unsigned DEPTH  = OSD_ROWS * OSD_COLS;
    localparam int unsigned SCW    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned SRW    = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int unsigned CW     = (OSD_COLS > 1) ? $clog2(OSD_COLS) : 1;
    localparam int unsigned RW     = (OSD_ROWS > 1) ? $clog2(OSD_ROWS) : 1;
    localparam int unsigned BCW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0] X_LO = 11'(OSD_X0);
    localparam logic [10:0] X_HI = 11'(OSD_X0 + OSD_COLS * CELL_W);
    localparam logic [10:0] Y_LO = 11'(OSD_Y0);
    localparam logic [10:0] Y_HI = 11'(OSD_Y0 + OSD_ROWS * CELL_H);
    localparam logic [4:0]  SPACE = 5'h1E;

    typedef enum logic [0:0] {ST_CLEAR, ST_RUN} state_t;

    state_t            state;
    logic [9:0]        clr_addr;
    logic              ram_we;
    logic [9:0]        ram_waddr;
    logic [5:0]        ram_wdata;
    logic [5:0]        text_mem [DEPTH];
    logic [5:0]        rdata;

    logic [BCW-1:0]    blink_cnt;
    logic              blink_phase;

    logic              in_area;
    logic              at_x0;
    logic [SCW-1:0]    cur_sub_col;
    logic [CW-1:0]     cur_col;
    logic [SRW-1:0]    cur_sub_row;
    logic [RW-1:0]     cur_row;
    logic [31:0]       rd_lin;
    logic [7:0]        sel_pix;

    logic [SCW-1:0]    sub_col;
    logic [CW-1:0]     col;
    logic [SRW-1:0]    sub_row;
    logic [RW-1:0]     row;
    logic              s1_valid, s1_in_area, s1_osd, s1_phase;
    logic [7:0]        s1_pix;
    logic              border;

    logic              s2_valid, s2_overlay, s2_draw;
    logic [7:0]        s2_pix;
    logic [7:0]        exp_r, exp_g, exp_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_CLEAR;
            clr_addr       <= '0;
            bus.text_ready <= 1'b0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == 10'(DEPTH - 1)) begin
                state          <= ST_RUN;
                bus.text_ready <= 1'b1;
            end else begin
                clr_addr <= clr_addr + 10'd1;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = {1'b0, SPACE};
        if (state == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (bus.text_we && (32'(bus.text_addr) < DEPTH)) begin
            ram_we    = 1'b1;
            ram_waddr = bus.text_addr;
            ram_wdata = {bus.text_wdata[7], bus.text_wdata[4:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we)
            text_mem[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BCW'(1);
            end
        end
    end

    // Cell position for the incoming pixel, tracked incrementally from the raster order.
    always_comb begin
        at_x0   = (bus.pixel_x_pos == X_LO[9:0]);
        in_area = bus.pixel_valid
                  && ({1'b0, bus.pixel_x_pos} >= X_LO) && ({1'b0, bus.pixel_x_pos} < X_HI)
                  && ({1'b0, bus.pixel_y_pos} >= Y_LO) && ({1'b0, bus.pixel_y_pos} < Y_HI);
        cur_sub_col = sub_col;
        cur_col     = col;
        cur_sub_row = sub_row;
        cur_row     = row;
        if (bus.pixel_valid && at_x0) begin
            cur_sub_col = '0;
            cur_col     = '0;
            if (bus.pixel_y_pos == Y_LO[9:0]) begin
                cur_sub_row = '0;
                cur_row     = '0;
            end else if ({1'b0, bus.pixel_y_pos} > Y_LO) begin
                if (sub_row == SRW'(CELL_H - 1)) begin
                    cur_sub_row = '0;
                    cur_row     = row + RW'(1);
                end else begin
                    cur_sub_row = sub_row + SRW'(1);
                end
            end
        end else if (in_area) begin
            if (sub_col == SCW'(CELL_W - 1)) begin
                cur_sub_col = '0;
                cur_col     = col + CW'(1);
            end else begin
                cur_sub_col = sub_col + SCW'(1);
            end
        end
        rd_lin = 32'(cur_row) * OSD_COLS + 32'(cur_col);
    end

    always_comb begin
        sel_pix = bus.frame_pixels[7:0];
        for (int unsigned k = 1; k < FRAME_COUNT; k++) begin
            if (bus.frame_select == FSEL_W'(k))
                sel_pix = bus.frame_pixels[8*k +: 8];
        end
    end

    // S1: the blink phase travels with the pixel so a same-cycle frame_start affects only later pixels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sub_col    <= '0;
            col        <= '0;
            sub_row    <= '0;
            row        <= '0;
            s1_valid   <= 1'b0;
            s1_in_area <= 1'b0;
            s1_osd     <= 1'b0;
            s1_phase   <= 1'b0;
            s1_pix     <= '0;
            rdata      <= '0;
        end else begin
            sub_col    <= cur_sub_col;
            col        <= cur_col;
            sub_row    <= cur_sub_row;
            row        <= cur_row;
            s1_valid   <= bus.pixel_valid;
            s1_in_area <= in_area;
            s1_osd     <= bus.osd_display;
            s1_phase   <= blink_phase;
            s1_pix     <= sel_pix;
            rdata      <= (rd_lin < DEPTH) ? text_mem[rd_lin[9:0]] : '0;
        end
    end

    always_comb begin
        border = (sub_col == '0) || (sub_col == SCW'(CELL_W - 1))
              || (sub_row == '0) || (sub_row == SRW'(CELL_H - 1));
        font_character = '0;
        font_line      = '0;
        font_column    = '0;
        if (s1_in_area) begin
            if (border) begin
                font_character = SPACE;
            end else begin
                font_character = (rdata[5] && s1_phase) ? SPACE : rdata[4:0];
                font_line      = 4'(sub_row - SRW'(1));
                font_column    = 3'(sub_col - SCW'(1));
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            s2_overlay <= 1'b0;
            s2_draw    <= 1'b0;
            s2_pix     <= '0;
        end else begin
            s2_valid   <= s1_valid;
            s2_overlay <= s1_in_area && s1_osd;
            s2_draw    <= s1_in_area && font_pixel;
            s2_pix     <= s1_pix;
        end
    end

    always_comb begin
        exp_r = {s2_pix[2:0], 5'b0};
        exp_g = {s2_pix[5:3], 5'b0};
        exp_b = {s2_pix[7:6], 6'b0};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.pixel_out_valid <= 1'b0;
            bus.pixel_red       <= '0;
            bus.pixel_green     <= '0;
            bus.pixel_blue      <= '0;
        end else begin
            bus.pixel_out_valid <= s2_valid;
            if (s2_valid) begin
                if (!s2_overlay) begin
                    bus.pixel_red   <= exp_r;
                    bus.pixel_green <= exp_g;
                    bus.pixel_blue  <= exp_b;
                end else if (s2_draw) begin
                    bus.pixel_red   <= 8'hD5;
                    bus.pixel_green <= 8'hC4;
                    bus.pixel_blue  <= 8'hA1;
                end else begin
                    bus.pixel_red   <= exp_r >> 3;
                    bus.pixel_green <= exp_g >> 3;
                    bus.pixel_blue  <= exp_b >> 3;
                end
            end
        end
    end
endmodule

// File: tb/tb_osd_text_compositor.sv
// Directed bench for osd_text_compositor: hand-computed vector table plus model-checked raster scans.
module tb_osd_text_compositor;
    localparam int unsigned FC = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    osd_text_compositor_if #(.FRAME_COUNT(FC)) bus();

    logic [4:0] font_character;
    logic [3:0] font_line;
    logic [2:0] font_column;
    logic       font_pixel;

    function automatic logic glyph(input logic [4:0] c, input logic [3:0] l, input logic [2:0] k);
        return (c != 5'h1E) && (((int'(l) + int'(k) + int'(c)) % 3) == 0);
    endfunction

    assign font_pixel = glyph(font_character, font_line, font_column);

    osd_text_compositor #(.FRAME_COUNT(FC)) dut (
        .clock          (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .font_character (font_character),
        .font_line      (font_line),
        .font_column    (font_column),
        .font_pixel     (font_pixel)
    );

    typedef struct { int x; int y; logic [23:0] rgb; } exp_t;
    typedef struct { int x; int y; logic [1:0] sel; logic osd; logic [23:0] rgb; } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic        chk_en;
    logic [2:0]  vsh;
    exp_t        expq[$];
    logic [23:0] last_exp;
    logic [5:0]  tmem [768];
    logic        phase_m;
    int          bcnt_m;
    logic        ready_m;
    vec_t        tbl [13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 768; i++) tmem[i] = {1'b0, 5'h1E};
        phase_m = 1'b0;
        bcnt_m  = 0;
        ready_m = 1'b0;
    endtask

    task automatic model_write(input int a, input logic [7:0] d);
        if (ready_m && a < 768) tmem[a] = {d[7], d[4:0]};
    endtask

    function automatic logic [23:0] model_rgb(input int x, input int y);
        logic [7:0] p, er, eg, eb;
        logic [5:0] a;
        logic [4:0] code;
        int s, cx, cy, l, k;
        s = int'(bus.frame_select);
        if (s < 3) p = bus.frame_pixels[s*8 +: 8];
        else       p = bus.frame_pixels[7:0];
        er = {p[2:0], 5'b0};
        eg = {p[5:3], 5'b0};
        eb = {p[7:6], 6'b0};
        if (!(x >= 160 && x < 480 && y >= 24 && y < 456) || !bus.osd_display)
            return {er, eg, eb};
        cx = (x - 160) % 10;
        cy = (y - 24) % 18;
        if (cx == 0 || cx == 9 || cy == 0 || cy == 17) begin
            code = 5'h1E; l = 0; k = 0;
        end else begin
            a = tmem[((y - 24) / 18) * 32 + (x - 160) / 10];
            code = (a[5] && phase_m) ? 5'h1E : a[4:0];
            l = cy - 1;
            k = cx - 1;
        end
        if (glyph(code, 4'(l), 3'(k))) return 24'hD5C4A1;
        return {er >> 3, eg >> 3, eb >> 3};
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        vsh = {vsh[1:0], bus.pixel_valid};
        if (chk_en) begin
            check("out_valid", 32'(bus.pixel_out_valid), 32'(vsh[2]));
            if (vsh[2]) begin
                if (expq.size() == 0) begin
                    check("exp_queue_empty", 32'(1), 32'(0));
                end else begin
                    e = expq.pop_front();
                    check($sformatf("pix(%0d,%0d)", e.x, e.y),
                          32'({bus.pixel_red, bus.pixel_green, bus.pixel_blue}), 32'(e.rgb));
                    last_exp = e.rgb;
                end
            end else begin
                check("rgb_hold", 32'({bus.pixel_red, bus.pixel_green, bus.pixel_blue}), 32'(last_exp));
            end
        end
    endtask

    task automatic drain();
        bus.pixel_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_ready(input logic drop);
        for (int i = 1; i <= 768; i++) begin
            if (drop && i == 5) begin
                bus.text_we    = 1'b1;
                bus.text_addr  = 10'd0;
                bus.text_wdata = 8'h01;
                model_write(0, 8'h01);
            end
            tick();
            bus.text_we = 1'b0;
            if (i == 767) check("ready_low_767", 32'(bus.text_ready), 32'(0));
            if (i == 768) check("ready_high_768", 32'(bus.text_ready), 32'(1));
        end
        ready_m = 1'b1;
    endtask

    task automatic write_text(input int a, input logic [7:0] d);
        bus.text_we    = 1'b1;
        bus.text_addr  = 10'(a);
        bus.text_wdata = d;
        tick();
        bus.text_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic scan(input int ya, input int yb, input int xa, input int xb,
                        input int wx, input int wy, input int wa, input logic [7:0] wd);
        exp_t e;
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                bus.pixel_valid = 1'b1;
                bus.pixel_x_pos = 10'(x);
                bus.pixel_y_pos = 10'(y);
                e = '{x, y, model_rgb(x, y)};
                expq.push_back(e);
                if (x == wx && y == wy) begin
                    bus.text_we    = 1'b1;
                    bus.text_addr  = 10'(wa);
                    bus.text_wdata = wd;
                end
                tick();
                if (x == wx && y == wy) begin
                    bus.text_we = 1'b0;
                    model_write(wa, wd);
                end
            end
        end
        drain();
    endtask

    task automatic pulse_fs(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            tick();
            bcnt_m++;
            if (bcnt_m == 30) begin
                bcnt_m  = 0;
                phase_m = ~phase_m;
            end
        end
    endtask

    initial begin
        exp_t e;
        // frame 2 = 5A, frame 1 = C7, frame 0 = 38
        tbl[0]  = '{0,   0,   2'd1, 1'b1, 24'hE000C0};
        tbl[1]  = '{0,   0,   2'd3, 1'b1, 24'h00E000};
        tbl[2]  = '{0,   0,   2'd0, 1'b1, 24'h00E000};
        tbl[3]  = '{1,   0,   2'd2, 1'b1, 24'h406040};
        tbl[4]  = '{160, 24,  2'd1, 1'b1, 24'h1C0018};
        tbl[5]  = '{160, 24,  2'd1, 1'b0, 24'hE000C0};
        tbl[6]  = '{479, 24,  2'd1, 1'b1, 24'h1C0018};
        tbl[7]  = '{480, 24,  2'd1, 1'b1, 24'hE000C0};
        tbl[8]  = '{159, 24,  2'd1, 1'b1, 24'hE000C0};
        tbl[9]  = '{160, 455, 2'd2, 1'b1, 24'h080C08};
        tbl[10] = '{160, 456, 2'd2, 1'b1, 24'h406040};
        tbl[11] = '{160, 23,  2'd0, 1'b1, 24'h00E000};
        tbl[12] = '{160, 300, 2'd0, 1'b1, 24'h001C00};

        bus.pixel_valid  = 1'b0;
        bus.pixel_x_pos  = '0;
        bus.pixel_y_pos  = '0;
        bus.frame_pixels = 24'h5AC738;
        bus.frame_select = 2'd1;
        bus.frame_start  = 1'b0;
        bus.osd_display  = 1'b1;
        bus.text_we      = 1'b0;
        bus.text_addr    = '0;
        bus.text_wdata   = '0;
        chk_en   = 1'b0;
        vsh      = '0;
        last_exp = '0;
        reset_n  = 1'b0;
        model_reset();

        repeat (3) tick();
        check("reset_out", 32'({bus.pixel_out_valid, bus.pixel_red, bus.pixel_green, bus.pixel_blue}), 32'(0));
        check("reset_font", 32'({bus.text_ready, font_character, font_line, font_column}), 32'(0));
        reset_n = 1'b1;
        chk_en  = 1'b1;
        wait_ready(1'b1);

        for (int i = 0; i < 13; i++) begin
            bus.pixel_valid  = 1'b1;
            bus.pixel_x_pos  = 10'(tbl[i].x);
            bus.pixel_y_pos  = 10'(tbl[i].y);
            bus.frame_select = tbl[i].sel;
            bus.osd_display  = tbl[i].osd;
            e = '{tbl[i].x, tbl[i].y, tbl[i].rgb};
            expq.push_back(e);
            tick();
        end
        drain();

        bus.osd_display  = 1'b1;
        bus.frame_select = 2'd1;
        scan(24, 41, 160, 179, -1, -1, 0, 8'h00);
        write_text(0, 8'h01);
        scan(24, 41, 160, 179, -1, -1, 0, 8'h00);
        scan(24, 25, 160, 169, 163, 25, 0, 8'h02);

        bus.frame_select = 2'd2;
        write_text(33, 8'h88);
        scan(24, 59, 160, 179, -1, -1, 0, 8'h00);
        pulse_fs(30);
        scan(24, 59, 160, 179, -1, -1, 0, 8'h00);
        pulse_fs(30);
        scan(24, 59, 160, 179, -1, -1, 0, 8'h00);

        write_text(767, 8'h03);
        write_text(736, 8'h04);
        write_text(735, 8'h05);
        scan(24, 437, 160, 160, -1, -1, 0, 8'h00);
        scan(438, 456, 160, 483, -1, -1, 0, 8'h00);

        bus.frame_select = 2'd1;
        for (int i = 0; i < 4; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_x_pos = 10'd0;
            bus.pixel_y_pos = 10'd0;
            e = '{0, 0, model_rgb(0, 0)};
            expq.push_back(e);
            tick();
        end
        bus.pixel_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_out", 32'({bus.pixel_out_valid, bus.pixel_red, bus.pixel_green, bus.pixel_blue}), 32'(0));
        check("midreset_ready", 32'(bus.text_ready), 32'(0));
        chk_en = 1'b0;
        expq.delete();
        vsh      = '0;
        last_exp = '0;
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        wait_ready(1'b0);
        scan(24, 41, 160, 179, -1, -1, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
